// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcode encodings, controller states and default
//               execute latencies for the ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Opcode encodings presented on cmd_op / alu_op
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MULT = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_NAND = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;

    // Default execute latencies for the multi-cycle operations
    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcodes 13..15 have no defined operation
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_NOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_lat_cnt
// Description : Execute-latency down-counter. Loaded with L-1 at command
//               acceptance, decremented while executing, flags zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_lat_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge CLK) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Command sequencer for an external combinational ALU. Accepts
//               a command, holds operands on the ALU bus for the opcode's
//               latency, captures the result, and presents it on a
//               valid/ready response port. Maintains an accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W       = 16,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_op,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    input  logic           cmd_acc,
    input  logic           acc_clr,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [3:0]     alu_op,
    input  logic [2*W-1:0] alu_result,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_data,
    output logic           res_ovf,
    output logic           res_err,
    output logic [W-1:0]   acc,
    output logic           busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     a_sel;
    logic             accept;
    logic             is_nop;
    logic             div_zero;
    logic             err_start;
    logic             exec_start;
    logic [CNT_W-1:0] lat_ld;
    logic             cnt_zero;
    logic             capture;
    logic             release_rsp;
    logic             ovf;

    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign is_nop      = (cmd_op == OP_NOP);
    assign div_zero    = (cmd_op == OP_DIV) && (cmd_b == '0);
    assign err_start   = accept && (!op_is_legal(cmd_op) || div_zero);
    assign exec_start  = accept && !is_nop && op_is_legal(cmd_op) && !div_zero;
    assign a_sel       = cmd_acc ? acc : cmd_a;
    assign capture     = (state == ST_EXEC) && cnt_zero;
    assign release_rsp = (state == ST_RESP) && res_ready;

    // ALU bus carries the registered command only while executing
    assign alu_op = (state == ST_EXEC) ? op_q : 4'd0;
    assign alu_a  = (state == ST_EXEC) ? a_q  : '0;
    assign alu_b  = (state == ST_EXEC) ? b_q  : '0;

    // Counter preload is L-1 so that zero marks the final execute cycle
    always_comb begin
        lat_ld = '0;
        if (cmd_op == OP_MULT) begin
            lat_ld = MUL_LD;
        end else if (cmd_op == OP_DIV) begin
            lat_ld = DIV_LD;
        end
    end

    alu_seq_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .CLK      (CLK),
        .reset    (reset),
        .load     (exec_start),
        .load_val (lat_ld),
        .dec      (state == ST_EXEC),
        .zero     (cnt_zero)
    );

    // Overflow is judged on the registered operands and the live ALU result
    always_comb begin
        ovf = 1'b0;
        case (op_q)
            OP_ADD:  ovf = alu_result[W];
            OP_SUB:  ovf = (a_q < b_q);
            OP_MULT: ovf = |alu_result[2*W-1:W];
            default: ovf = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: errors bypass EXEC, NOP stays idle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (err_start) begin
                    state_nxt = ST_RESP;
                end else if (exec_start) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, response registers and accumulator
    always_ff @(posedge CLK) begin
        if (reset) begin
            op_q      <= 4'd0;
            a_q       <= '0;
            b_q       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
            res_err   <= 1'b0;
            acc       <= '0;
        end else begin
            if (accept) begin
                op_q <= cmd_op;
                a_q  <= a_sel;
                b_q  <= cmd_b;
            end

            if (err_start) begin
                res_valid <= 1'b1;
                res_err   <= 1'b1;
                res_ovf   <= 1'b0;
                res_data  <= div_zero ? {(2*W){1'b1}} : '0;
            end else if (capture) begin
                res_valid <= 1'b1;
                res_err   <= 1'b0;
                res_ovf   <= ovf;
                res_data  <= alu_result;
            end else if (release_rsp) begin
                res_valid <= 1'b0;
            end

            if (acc_clr) begin
                acc <= '0;
            end else if (capture) begin
                acc <= alu_result[W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        CLK;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_acc;
    logic        acc_clr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_ovf;
    logic        res_err;
    logic [15:0] acc;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    alu_sequencer dut (
        .CLK        (CLK),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_acc    (cmd_acc),
        .acc_clr    (acc_clr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .res_err    (res_err),
        .acc        (acc),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External ALU model
    always_comb begin
        logic [31:0] ea;
        logic [31:0] eb;
        ea = {16'h0, alu_a};
        eb = {16'h0, alu_b};
        alu_result = 32'h0;
        case (alu_op)
            4'd1:  alu_result = ea + eb;
            4'd2:  alu_result = {16'h0, alu_a - alu_b};
            4'd3:  alu_result = ea * eb;
            4'd4:  alu_result = (alu_b != 16'h0) ? {alu_a % alu_b, alu_a / alu_b} : 32'hFFFF_FFFF;
            4'd5:  alu_result = {16'h0, alu_a << alu_b[3:0]};
            4'd6:  alu_result = {16'h0, alu_a >> alu_b[3:0]};
            4'd7:  alu_result = {16'h0, alu_a & alu_b};
            4'd8:  alu_result = {16'h0, alu_a | alu_b};
            4'd9:  alu_result = {16'h0, alu_a ^ alu_b};
            4'd10: alu_result = {16'h0, ~alu_a};
            4'd11: alu_result = {16'h0, ~(alu_a & alu_b)};
            4'd12: alu_result = {16'h0, ~(alu_a | alu_b)};
            default: alu_result = 32'h0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response handshake is pending
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (res_valid && res_ready && !reset) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got data %0h with empty scoreboard", res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", {32'h0, res_data}, {32'h0, e.data});
                    chk("res_ovf", {63'h0, res_ovf}, {63'h0, e.ovf});
                    chk("res_err", {63'h0, res_err}, {63'h0, e.err});
                end
            end
        end
    end

    // Issue one command; exp_lat=0 means no response is expected
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic use_acc, input int exp_lat, input logic [31:0] e_data,
                        input logic e_ovf, input logic e_err, input logic clr);
        int   n;
        exp_t e;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = use_acc;
        if (exp_lat > 0) begin
            e.data = e_data;
            e.ovf  = e_ovf;
            e.err  = e_err;
            sb.push_back(e);
        end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_acc   = 1'b0;
        if (clr) acc_clr = 1'b1;
        if (exp_lat >= 2 && !e_err) begin
            chk("alu_op_exec", {60'h0, alu_op}, {60'h0, op});
            chk("alu_b_exec", {48'h0, alu_b}, {48'h0, b});
        end
        if (exp_lat > 0) begin
            n = 1;
            while (!res_valid && n < 50) begin
                @(posedge CLK); #1;
                n++;
            end
            chk("latency", 64'(n), 64'(exp_lat));
        end
        acc_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] snap;
        logic        saw;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_a     = 16'h0;
        cmd_b     = 16'h0;
        cmd_acc   = 1'b0;
        acc_clr   = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_res_valid", {63'h0, res_valid}, 64'd0);
        chk("rst_acc", {48'h0, acc}, 64'd0);
        chk("rst_res_data", {32'h0, res_data}, 64'd0);
        chk("rst_alu_op", {60'h0, alu_op}, 64'd0);
        chk("rst_alu_a", {48'h0, alu_a}, 64'd0);

        // ADD carry-out
        send(4'd1, 16'hFFFF, 16'h0001, 1'b0, 2, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
        chk("acc_add_wrap", {48'h0, acc}, 64'h0);
        // MULT with high half set
        send(4'd3, 16'd300, 16'd300, 1'b0, 3, 32'd90000, 1'b1, 1'b0, 1'b0);
        chk("acc_mult", {48'h0, acc}, 64'h5F90);
        // DIV by zero: error, accumulator untouched
        send(4'd4, 16'd100, 16'd0, 1'b0, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("acc_div0", {48'h0, acc}, 64'h5F90);
        // Accumulator chaining
        send(4'd1, 16'd5, 16'd3, 1'b0, 2, 32'd8, 1'b0, 1'b0, 1'b0);
        chk("acc_add1", {48'h0, acc}, 64'd8);
        send(4'd1, 16'hDEAD, 16'd2, 1'b1, 2, 32'd10, 1'b0, 1'b0, 1'b0);
        chk("acc_add2", {48'h0, acc}, 64'd10);
        // SUB borrow
        send(4'd2, 16'd3, 16'd5, 1'b0, 2, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0);
        chk("acc_sub", {48'h0, acc}, 64'hFFFE);
        // Illegal opcode
        send(4'd14, 16'd1, 16'd1, 1'b0, 1, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("acc_illegal", {48'h0, acc}, 64'hFFFE);
        // DIV full latency
        send(4'd4, 16'd100, 16'd7, 1'b0, 5, 32'h0002_000E, 1'b0, 1'b0, 1'b0);
        chk("acc_div", {48'h0, acc}, 64'h000E);
        // NOP: accepted, no response, stays idle
        send(4'd0, 16'd9, 16'd9, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("nop_cmd_ready", {63'h0, cmd_ready}, 64'd1);
        chk("nop_busy", {63'h0, busy}, 64'd0);
        chk("acc_nop", {48'h0, acc}, 64'h000E);

        // Backpressure: response must hold while res_ready is low
        res_ready = 1'b0;
        send(4'd9, 16'hF0F0, 16'h0FF0, 1'b0, 2, 32'h0000_FF00, 1'b0, 1'b0, 1'b0);
        snap = res_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("stall_valid", {63'h0, res_valid}, 64'd1);
            chk("stall_data", {32'h0, res_data}, 64'h0000_FF00);
            chk("stall_cmd_ready", {63'h0, cmd_ready}, 64'd0);
        end
        chk("stall_snap", {32'h0, snap}, 64'h0000_FF00);
        res_ready = 1'b1;

        // Clear coincident with capture wins
        send(4'd1, 16'd1, 16'd1, 1'b0, 2, 32'd2, 1'b0, 1'b0, 1'b1);
        chk("acc_clr_capture", {48'h0, acc}, 64'd0);
        send(4'd1, 16'd20, 16'd22, 1'b0, 2, 32'd42, 1'b0, 1'b0, 1'b0);
        chk("acc_after_clr", {48'h0, acc}, 64'd42);

        // Reset in the middle of a DIV aborts it
        send(4'd4, 16'd100, 16'd5, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("abort_busy_before", {63'h0, busy}, 64'd1);
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        chk("abort_busy", {63'h0, busy}, 64'd0);
        chk("abort_cmd_ready", {63'h0, cmd_ready}, 64'd1);
        chk("abort_acc", {48'h0, acc}, 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) saw = 1'b1;
            @(posedge CLK); #1;
        end
        chk("abort_no_resp", {63'h0, saw}, 64'd0);

        repeat (3) @(posedge CLK);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, operand width.
REQ-002 SHALL have parameter MUL_LAT, default 2, MULT execute cycles (>=1).
REQ-003 SHALL have parameter DIV_LAT, default 4, DIV execute cycles (>=1).
REQ-004 SHALL have port CLK  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-007 SHALL have ports cmd_op in 4 opcode, cmd_a in W, cmd_b in W, cmd_acc in 1 (use accumulator as A operand).
REQ-008 SHALL have port acc_clr  in  1  synchronous accumulator clear.
REQ-009 SHALL have ports alu_a out W, alu_b out W, alu_op out 4: drive to external ALU.
REQ-010 SHALL have port alu_result  in  2W  external ALU result, combinational from alu_a/alu_b/alu_op.
REQ-011 SHALL have ports res_valid out 1, res_ready in 1, res_data out 2W, res_ovf out 1, res_err out 1.
REQ-012 SHALL have ports acc out W (accumulator value) and busy out 1 (state != IDLE).

Function
REQ-013 Opcodes SHALL be 0 NOP, 1 ADD, 2 SUB, 3 MULT, 4 DIV, 5 SLL, 6 SRL, 7 AND, 8 OR, 9 XOR, 10 NOT, 11 NAND, 12 NOR; 13-15 illegal.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; cmd_ready=1 only in IDLE.
REQ-015 Acceptance SHALL occur on an edge with cmd_valid & cmd_ready; op, A (acc if cmd_acc else cmd_a) and B are registered.
REQ-016 NOP SHALL be accepted, produce no response, and leave state IDLE.
REQ-017 Legal non-NOP ops SHALL go IDLE->EXEC; latency L=1 for all except MULT (MUL_LAT) and DIV (DIV_LAT).
REQ-018 In EXEC, alu_a/alu_b/alu_op SHALL hold registered operands; a down-counter loaded with L-1 decrements each cycle.
REQ-019 On the EXEC cycle with counter==0, alu_result SHALL be captured into res_data; state -> RESP.
REQ-020 res_valid SHALL rise L+1 cycles after the acceptance edge and hold, with stable res_*, until res_valid & res_ready; then -> IDLE.
REQ-021 Illegal opcode SHALL skip EXEC: -> RESP next cycle, res_err=1, res_data=0.
REQ-022 DIV with B==0 SHALL skip EXEC: -> RESP next cycle, res_err=1, res_data=all ones.
REQ-023 res_ovf SHALL be: ADD result[W]; SUB A<B (unsigned); MULT result[2W-1:W]!=0; else 0.
REQ-024 Each non-error completion SHALL load acc with res_data[W-1:0] on the capture edge.
REQ-025 acc_clr SHALL zero acc next edge in any state; clear SHALL win over simultaneous capture.
REQ-026 Outside EXEC, alu_op SHALL be 0 and alu_a/alu_b SHALL be 0.

Reset
REQ-027 reset SHALL force state IDLE, acc=0, counter=0, res_data=0, res_valid=0, res_ovf=0, res_err=0, alu_*=0; cmd_ready=1 the cycle after.
REQ-028 reset during EXEC or RESP SHALL abort the operation with no response issued; reset SHALL win over acc_clr and capture.

Structure
REQ-029 Package alu_seq_pkg SHALL hold opcode constants, state enum, and default latency constants.
REQ-030 The latency counter SHALL be a sub-module alu_seq_lat_cnt (load, decrement, zero flag).
REQ-031 The block SHALL not instantiate the ALU; it is a pure controller.

Verification
REQ-032 ADD A=16'hFFFF, B=1, res_ready=1 -> res_valid 2 cycles after accept, res_data=32'h0001_0000, res_ovf=1, acc=0.
REQ-033 MULT A=300, B=300, default MUL_LAT -> res_valid 3 cycles after accept, res_data=90000, res_ovf=1.
REQ-034 DIV A=100, B=0 -> res_valid 1 cycle after accept, res_err=1, res_data=32'hFFFF_FFFF, acc unchanged.
REQ-035 ADD A=5,B=3 then ADD cmd_acc=1,B=2 -> results 8 then 10; acc=10.
REQ-036 res_ready held 0 for 5 cycles -> res_* stable, cmd_ready=0; acc_clr with capture -> acc=0.
REQ-037 reset asserted mid-DIV -> no res_valid, busy=0 and cmd_ready=1 after reset release.
